// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared UART definitions used by the transmitter (and the matching receiver):
//   - uart_state_e  : frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   - UART_DATA_BITS: data bits per frame (8)
//   - cnt_w()       : width of a counter that must hold 0..DIV-1
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Width of a counter running 0..div-1; never narrower than one bit.
    function automatic int cnt_w(input int div);
        return (div <= 2) ? 1 : $clog2(div);
    endfunction

endpackage

// File: rtl/uart_tx_if.sv
// -----------------------------------------------------------------------------
// uart_tx_if
// Byte-producer <-> transmitter handshake plus the serial line.
//   in     [7:0] byte to send, valid only while in_stb=1
//   in_stb       one-cycle write strobe
//   out          serial line, idle high
//   ready        holding register empty (registered)
//   busy         frame in progress or byte held (registered)
//   ovf          one-cycle pulse: strobe arrived while ready=0, byte dropped
// Modports: master = byte producer, slave = transmitter.
// -----------------------------------------------------------------------------
interface uart_tx_if;

    logic [7:0] in;
    logic       in_stb;
    logic       out;
    logic       ready;
    logic       busy;
    logic       ovf;

    modport master (
        output in,
        output in_stb,
        input  out,
        input  ready,
        input  busy,
        input  ovf
    );

    modport slave (
        input  in,
        input  in_stb,
        output out,
        output ready,
        output busy,
        output ovf
    );

endinterface

// File: rtl/uart_baud_gen.sv
// -----------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer: counts 0..DIV-1 and flags the last cycle of each bit.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  synchronous reset, active-low
//   i_clr   in  synchronous clear; holds the count at 0 (line idle)
//   o_tick  out one-cycle pulse on the final cycle of a bit period
// Parameter DIV: clk cycles per bit (>= 2).
// -----------------------------------------------------------------------------
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int DIV = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);

    localparam int            CW   = cnt_w(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Held in clear while idle, so the first bit of a frame gets a full period.
    assign o_tick = w_last & ~i_clr;

endmodule

// File: rtl/uart_tx.sv
// -----------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter (8N1 by default). Bytes are written by a one-cycle
// strobe into a single holding register; while a frame is on the line the next
// byte can already be held, so frames follow each other with no idle gap.
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   synchronous reset, active-low (aborts any frame in flight)
//   bus    slave modport of uart_tx_if (in, in_stb, out, ready, busy, ovf)
// Parameters:
//   DIV         clk cycles per bit (>= 2)
//   PARITY_ODD  parity sense, present only with UART_TX_PARITY_EN (0 even, 1 odd)
// Configuration macro:
//   UART_TX_PARITY_EN  adds a parity bit after data bit 7 (8E1 / 8O1).
// -----------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int DIV = 5
`ifdef UART_TX_PARITY_EN
    , parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_tx_if.slave  bus
);

    uart_state_e r_state, w_state_n;
    logic [UART_DATA_BITS-1:0] r_hold, w_hold_n;
    logic [UART_DATA_BITS-1:0] r_shreg, w_shreg_n;
    logic [2:0] r_bitcnt, w_bitcnt_n;
    logic r_ready, w_ready_n;
    logic r_busy, w_busy_n;
    logic r_ovf, w_ovf_n;
    logic w_load;
    logic w_tick;
    logic w_clr;
    logic w_out;
`ifdef UART_TX_PARITY_EN
    logic r_par, w_par_n;
`endif

    assign w_clr = (r_state == ST_IDLE);

    uart_baud_gen #(
        .DIV (DIV)
    ) u_baud (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    // Next-state and next-register logic.
    always_comb begin
        w_state_n  = r_state;
        w_hold_n   = r_hold;
        w_shreg_n  = r_shreg;
        w_bitcnt_n = r_bitcnt;
        w_ready_n  = r_ready;
        w_load     = 1'b0;
        // ready is the pre-edge value: a strobe while it is low is dropped even
        // if the holding register happens to drain in this same cycle.
        w_ovf_n    = bus.in_stb & ~r_ready;

        case (r_state)
            ST_IDLE: begin
                if (!r_ready) begin
                    w_state_n = ST_START;
                    w_load    = 1'b1;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_n = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shreg_n = {1'b0, r_shreg[UART_DATA_BITS-1:1]};
                    if (r_bitcnt == 3'd7) begin
                        w_bitcnt_n = 3'd0;
`ifdef UART_TX_PARITY_EN
                        w_state_n  = ST_PARITY;
`else
                        w_state_n  = ST_STOP;
`endif
                    end else begin
                        w_bitcnt_n = r_bitcnt + 3'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_n = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_tick) begin
                    // A held byte starts straight away: no idle cycle between frames.
                    if (!r_ready) begin
                        w_state_n = ST_START;
                        w_load    = 1'b1;
                    end else begin
                        w_state_n = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase

        if (w_load) begin
            w_shreg_n = r_hold;
            w_ready_n = 1'b1;
        end

        // Acceptance never coincides with a load: a load needs ready=0.
        if (bus.in_stb && r_ready) begin
            w_hold_n  = bus.in;
            w_ready_n = 1'b0;
        end

        w_busy_n = ~w_ready_n | (w_state_n != ST_IDLE);
    end

`ifdef UART_TX_PARITY_EN
    always_comb begin
        w_par_n = r_par;
        if (w_load) begin
            w_par_n = (^r_hold) ^ PARITY_ODD;
        end
    end
`endif

    // Control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= 3'd0;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_state_n;
            r_bitcnt <= w_bitcnt_n;
            r_ready  <= w_ready_n;
            r_busy   <= w_busy_n;
            r_ovf    <= w_ovf_n;
        end
    end

    // Data registers; their contents are only observed under valid control state.
    always_ff @(posedge clk) begin
        r_hold  <= w_hold_n;
        r_shreg <= w_shreg_n;
`ifdef UART_TX_PARITY_EN
        r_par   <= w_par_n;
`endif
    end

    // Line value decoded from registered state, so it is glitch-free per bit.
    always_comb begin
        w_out = 1'b1;
        case (r_state)
            ST_START: w_out = 1'b0;
            ST_DATA:  w_out = r_shreg[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: w_out = r_par;
`endif
            default:  w_out = 1'b1;
        endcase
    end

    assign bus.out   = w_out;
    assign bus.ready = r_ready;
    assign bus.busy  = r_busy;
    assign bus.ovf   = r_ovf;

endmodule

// File: tb/tb_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_tx
// Directed self-checking bench for uart_tx (DIV=5). With UART_TX_PARITY_EN
// defined, a second instance with odd parity runs alongside the even one.
// -----------------------------------------------------------------------------
module tb_uart_tx;

    localparam int DIV = 5;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * DIV;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    uart_tx_if bus ();

`ifdef UART_TX_PARITY_EN
    uart_tx #(.DIV(DIV), .PARITY_ODD(1'b0)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    uart_tx_if bus_o ();
    assign bus_o.in     = bus.in;
    assign bus_o.in_stb = bus.in_stb;
    uart_tx #(.DIV(DIV), .PARITY_ODD(1'b1)) dut_o (.clk(clk), .rst_n(rst_n), .bus(bus_o));
    logic lo [0:255];
`else
    uart_tx #(.DIV(DIV)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

    logic ln [0:255];
    logic rd [0:255];
    logic bz [0:255];
    logic ov [0:255];

    // Expected line value of frame bit k for byte d.
    function automatic logic fbit(input logic [7:0] d, input int k, input bit podd);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (NB == 11 && k == 9) return (^d) ^ podd;
        return 1'b1;
    endfunction

    // Number of line samples in a recorded frame that differ from the ideal frame.
    function automatic int frame_errs(input int off, input logic [7:0] d, input bit podd, input bit use_o);
        int n = 0;
        logic s;
        for (int j = 0; j < FL; j++) begin
            s = ln[off + j];
`ifdef UART_TX_PARITY_EN
            if (use_o) s = lo[off + j];
`endif
            if (s !== fbit(d, j / DIV, podd)) n++;
        end
        if (use_o && NB == 10) n++;
        return n;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rec(input int i);
        ln[i] = bus.out;
        rd[i] = bus.ready;
        bz[i] = bus.busy;
        ov[i] = bus.ovf;
`ifdef UART_TX_PARITY_EN
        lo[i] = bus_o.out;
`endif
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            rec(i);
        end
    endtask

    // The byte is only valid in the strobe cycle; garbage follows.
    task automatic send(input logic [7:0] b);
        bus.in = b;
        bus.in_stb = 1'b1;
        step();
        bus.in_stb = 1'b0;
        bus.in = ~b;
    endtask

    task automatic test_reset();
        bus.in = 8'h00;
        bus.in_stb = 1'b0;
        rst_n = 1'b0;
        step(); step(); step();
        checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL reset_out got=%b exp=1", bus.out); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.ovf); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_idle();
        int bad_o = 0, bad_r = 0, bad_b = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.out !== 1'b1) bad_o++;
            if (bus.ready !== 1'b1) bad_r++;
            if (bus.busy !== 1'b0) bad_b++;
        end
        checks++; if (bad_o !== 0) begin errors++; $display("FAIL idle_out bad_cycles=%0d exp=0", bad_o); end
        checks++; if (bad_r !== 0) begin errors++; $display("FAIL idle_ready bad_cycles=%0d exp=0", bad_r); end
        checks++; if (bad_b !== 0) begin errors++; $display("FAIL idle_busy bad_cycles=%0d exp=0", bad_b); end
    endtask

    task automatic test_single();
        int e;
        send(8'hA5);
        checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL single_ready_after_stb got=%b exp=0", bus.ready); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_stb got=%b exp=1", bus.busy); end
        checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL single_out_N1 got=%b exp=1", bus.out); end
        capture(FL + 2);
        checks++; if (ln[0] !== 1'b0) begin errors++; $display("FAIL single_start_N2 got=%b exp=0", ln[0]); end
        e = frame_errs(0, 8'hA5, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL single_frame bad_samples=%0d exp=0", e); end
        checks++; if (rd[0] !== 1'b1) begin errors++; $display("FAIL single_hold_free got=%b exp=1", rd[0]); end
        checks++; if (bz[FL-1] !== 1'b1) begin errors++; $display("FAIL single_busy_stop got=%b exp=1", bz[FL-1]); end
        checks++; if (bz[FL] !== 1'b0) begin errors++; $display("FAIL single_busy_end got=%b exp=0", bz[FL]); end
        checks++; if (ln[FL] !== 1'b1) begin errors++; $display("FAIL single_idle_after got=%b exp=1", ln[FL]); end
    endtask

    task automatic test_back_to_back();
        bit sent = 1'b0;
        int e;
        logic [7:0] d1, d2;
        send(8'h00);
        for (int i = 0; i < 2 * FL + 2; i++) begin
            step();
            rec(i);
            if (!sent && bus.ready) begin
                bus.in = 8'hFF;
                bus.in_stb = 1'b1;
                sent = 1'b1;
            end else begin
                bus.in_stb = 1'b0;
                bus.in = 8'h5C;
            end
        end
        bus.in_stb = 1'b0;
        checks++; if (sent !== 1'b1) begin errors++; $display("FAIL b2b_ready_timeout got=%b exp=1", sent); end
        e = frame_errs(0, 8'h00, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL b2b_frame1 bad_samples=%0d exp=0", e); end
        e = frame_errs(FL, 8'hFF, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL b2b_frame2 bad_samples=%0d exp=0", e); end
        for (int k = 0; k < 8; k++) begin
            d1[k] = ln[(1 + k) * DIV + DIV / 2];
            d2[k] = ln[FL + (1 + k) * DIV + DIV / 2];
        end
        checks++; if (d1 !== 8'h00) begin errors++; $display("FAIL b2b_decode1 got=%h exp=00", d1); end
        checks++; if (d2 !== 8'hFF) begin errors++; $display("FAIL b2b_decode2 got=%h exp=ff", d2); end
        checks++; if (bz[2*FL] !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got=%b exp=0", bz[2*FL]); end
    endtask

    task automatic test_overflow();
        int phase = 0, i33 = -1, ovcnt = 0, ovat = -1, idle_bad = 0, e;
        send(8'h11);
        for (int i = 0; i < 2 * FL + 10; i++) begin
            step();
            rec(i);
            if (ov[i] === 1'b1) begin
                ovcnt++;
                ovat = i;
            end
            bus.in_stb = 1'b0;
            if (phase == 0 && bus.ready) begin
                bus.in = 8'h22; bus.in_stb = 1'b1; phase = 1;
            end else if (phase == 1) begin
                bus.in = 8'h33; bus.in_stb = 1'b1; phase = 2; i33 = i;
            end
        end
        bus.in_stb = 1'b0;
        checks++; if (phase !== 2) begin errors++; $display("FAIL ovf_stimulus phase=%0d exp=2", phase); end
        checks++; if (i33 >= 0 && rd[i33] !== 1'b0) begin errors++; $display("FAIL ovf_ready_low got=%b exp=0", rd[i33]); end
        checks++; if (ovcnt !== 1) begin errors++; $display("FAIL ovf_pulses got=%0d exp=1", ovcnt); end
        checks++; if (ovat !== i33 + 1) begin errors++; $display("FAIL ovf_timing got=%0d exp=%0d", ovat, i33 + 1); end
        e = frame_errs(0, 8'h11, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL ovf_frame11 bad_samples=%0d exp=0", e); end
        e = frame_errs(FL, 8'h22, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL ovf_frame22 bad_samples=%0d exp=0", e); end
        for (int j = 2 * FL; j < 2 * FL + 10; j++) if (ln[j] !== 1'b1) idle_bad++;
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL ovf_33_not_sent bad_samples=%0d exp=0", idle_bad); end
    endtask

    task automatic test_mid_reset();
        int idle_bad = 0, e;
        send(8'h3C);
        capture(5 * DIV + 3);
        checks++; if (ln[5*DIV+2] !== 1'b1) begin errors++; $display("FAIL rst_bit4 got=%b exp=1", ln[5*DIV+2]); end
        checks++; if (ln[2*DIV+2] !== 1'b0) begin errors++; $display("FAIL rst_bit1 got=%b exp=0", ln[2*DIV+2]); end
        rst_n = 1'b0;
        step();
        checks++; if (bus.out !== 1'b1) begin errors++; $display("FAIL rst_mid_out got=%b exp=1", bus.out); end
        checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready got=%b exp=1", bus.ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", bus.busy); end
        rst_n = 1'b1;
        capture(4 * DIV);
        for (int j = 0; j < 4 * DIV; j++) if (ln[j] !== 1'b1) idle_bad++;
        checks++; if (idle_bad !== 0) begin errors++; $display("FAIL rst_frame_aborted bad_samples=%0d exp=0", idle_bad); end
        send(8'h5A);
        capture(FL + 1);
        e = frame_errs(0, 8'h5A, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL rst_next_frame bad_samples=%0d exp=0", e); end
        checks++; if (bz[FL] !== 1'b0) begin errors++; $display("FAIL rst_next_busy_end got=%b exp=0", bz[FL]); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        int e;
        send(8'h07);
        capture(FL + 1);
        checks++; if (ln[9*DIV+2] !== 1'b1) begin errors++; $display("FAIL par_even_bit got=%b exp=1", ln[9*DIV+2]); end
        checks++; if (lo[9*DIV+2] !== 1'b0) begin errors++; $display("FAIL par_odd_bit got=%b exp=0", lo[9*DIV+2]); end
        e = frame_errs(0, 8'h07, 1'b0, 1'b0);
        checks++; if (e !== 0) begin errors++; $display("FAIL par_even_frame bad_samples=%0d exp=0", e); end
        e = frame_errs(0, 8'h07, 1'b1, 1'b1);
        checks++; if (e !== 0) begin errors++; $display("FAIL par_odd_frame bad_samples=%0d exp=0", e); end
        checks++; if (bz[11*DIV-1] !== 1'b1) begin errors++; $display("FAIL par_len_stop got=%b exp=1", bz[11*DIV-1]); end
        checks++; if (bz[11*DIV] !== 1'b0) begin errors++; $display("FAIL par_len_end got=%b exp=0", bz[11*DIV]); end
    endtask
`endif

    initial begin
        test_reset();
        test_idle();
        test_single();
        capture(5);
        test_back_to_back();
        capture(5);
        test_overflow();
        capture(5);
        test_mid_reset();
`ifdef UART_TX_PARITY_EN
        capture(5);
        test_parity();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached, checks so far=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
